// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode/writeback port bundle for regfile_sb
interface regfile_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              busy_set;
  logic [ADDR_W-1:0] busy_addr;
  logic              busy1;
  logic              busy2;
  logic              init_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, busy_set, busy_addr,
    input  rd_data1, rd_data2, busy1, busy2, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, busy_set, busy_addr,
    output rd_data1, rd_data2, busy1, busy2, init_done
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with init sweep, write bypass and pending-write scoreboard
module regfile_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [DATA_W-1:0]  regs_q [DEPTH];

  logic run;
  logic wr_ok;
  logic hit1, hit2;
  logic [DATA_W-1:0] init_val;

  assign run      = (state_q == ST_RUN);
  assign wr_ok    = bus.wr_en && !((ZERO_R0 != 0) && (bus.wr_addr == '0));
  assign init_val = DATA_W'(cnt_q[ADDR_W-1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == (ADDR_W+1)'(DEPTH - 1)) state_d = ST_RUN;
    end else begin
      // clear before set so a same-edge issue to the written register wins
      if (bus.wr_en)    busy_d[bus.wr_addr]   = 1'b0;
      if (bus.busy_set) busy_d[bus.busy_addr] = 1'b1;
      if (ZERO_R0 != 0) busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Contents survive rst; the sweep rewrites every entry afterwards anyway.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) regs_q[cnt_q[ADDR_W-1:0]] <= init_val;
      else if (wr_ok)         regs_q[bus.wr_addr]       <= bus.wr_data;
    end
  end

  assign hit1 = wr_ok && (bus.wr_addr == bus.rd_addr1);
  assign hit2 = wr_ok && (bus.wr_addr == bus.rd_addr2);

  always_comb begin
    bus.rd_data1 = '0;
    bus.rd_data2 = '0;
    if (run) begin
      if (!((ZERO_R0 != 0) && (bus.rd_addr1 == '0)))
        bus.rd_data1 = hit1 ? bus.wr_data : regs_q[bus.rd_addr1];
      if (!((ZERO_R0 != 0) && (bus.rd_addr2 == '0)))
        bus.rd_data2 = hit2 ? bus.wr_data : regs_q[bus.rd_addr2];
    end
  end

  assign bus.busy1 = run && busy_q[bus.rd_addr1] &&
                     !(bus.wr_en && (bus.wr_addr == bus.rd_addr1));
  assign bus.busy2 = run && busy_q[bus.rd_addr2] &&
                     !(bus.wr_en && (bus.wr_addr == bus.rd_addr2));
  assign bus.init_done = run;
endmodule
